// File: rtl/dllp_pkg.sv
// Shared constants and types for the receive-side Ack/Nak DLLP parser.
package dllp_pkg;

    localparam logic [7:0]  TYPE_ACK = 8'h00;
    localparam logic [7:0]  TYPE_NAK = 8'h10;

    localparam logic [15:0] CRC_POLY = 16'h100B;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam logic [1:0]  AN_NONE  = 2'b00;
    localparam logic [1:0]  AN_ACK   = 2'b01;
    localparam logic [1:0]  AN_NAK   = 2'b10;

    // Index of the next expected DLLP word.
    typedef enum logic [1:0] {
        ST_W0 = 2'd0,
        ST_W1 = 2'd1,
        ST_W2 = 2'd2
    } dllp_state_e;

    function automatic logic [1:0] an_code(input logic [7:0] dllp_type);
        return (dllp_type == TYPE_ACK) ? AN_ACK : AN_NAK;
    endfunction

endpackage

// File: rtl/dllp_crc16.sv
// Combinational CRC-16 next state over one 16-bit word, MSB first.
module dllp_crc16
    import dllp_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [15:0] data,
    output logic [15:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 15; i >= 0; i--) begin
            crc_out = {crc_out[14:0], 1'b0} ^ ((crc_out[15] ^ data[i]) ? CRC_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/dllp_ack_nak_rx.sv
// Receive-side Ack/Nak DLLP parser feeding the replay buffer through a 1-deep result register.
// Optional CRC checking is built when DLLP_CRC_CHECK_EN is defined.
module dllp_ack_nak_rx
    import dllp_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] din,
    input  logic        din_valid,
    input  logic        sop,
    input  logic        busy_n,
    output logic [1:0]  ack_nack,
    output logic [11:0] seq,
    output logic        crc_err,
    output logic [7:0]  drop_cnt,
    output dllp_state_e fsm_state
);

    dllp_state_e state;
    logic [7:0]  type_q;
    logic [11:0] seq_q;
    logic        pend_valid;
    logic [1:0]  pend_an;
    logic [11:0] pend_seq;
    logic [11:0] last_seq;

    logic deliver;
    logic frame_done;
    logic truncated;
    logic crc_pass;
    logic is_acknak;
    logic wr;

    // Result handshake: a result is offered whenever pend_valid is set; busy_n=1 in
    // that same cycle completes the transfer and the slot frees at the next edge.
    assign deliver  = pend_valid & busy_n;
    assign ack_nack = deliver ? pend_an : AN_NONE;
    assign seq      = deliver ? pend_seq : last_seq;
    assign fsm_state = state;

    assign frame_done = din_valid & ~sop & (state == ST_W2);
    assign truncated  = din_valid & sop & (state != ST_W0);
    assign is_acknak  = (type_q == TYPE_ACK) || (type_q == TYPE_NAK);
    assign wr         = frame_done & crc_pass & is_acknak;

`ifdef DLLP_CRC_CHECK_EN
    logic [15:0] crc_q;
    logic [15:0] crc_seed;
    logic [15:0] crc_next;

    // A fresh frame (sop in any state) always restarts from the init value.
    assign crc_seed = ((state == ST_W1) && !sop) ? crc_q : CRC_INIT;
    assign crc_pass = (din == ~crc_q);

    dllp_crc16 u_crc (
        .crc_in  (crc_seed),
        .data    (din),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= CRC_INIT;
        end else if (din_valid && (sop || state == ST_W1)) begin
            crc_q <= crc_next;
        end
    end
`else
    assign crc_pass = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_W0;
            type_q     <= 8'h00;
            seq_q      <= 12'h000;
            pend_valid <= 1'b0;
            pend_an    <= AN_NONE;
            pend_seq   <= 12'h000;
            last_seq   <= 12'h000;
            crc_err    <= 1'b0;
            drop_cnt   <= 8'h00;
        end else begin
            crc_err <= truncated | (frame_done & ~crc_pass);

            if (deliver) begin
                last_seq <= pend_seq;
            end

            // Newest result wins; a drop is counted only if the old one was never taken.
            if (wr) begin
                pend_valid <= 1'b1;
                pend_an    <= an_code(type_q);
                pend_seq   <= seq_q;
                if (pend_valid && !deliver && drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (deliver) begin
                pend_valid <= 1'b0;
            end

            if (din_valid) begin
                if (sop) begin
                    type_q <= din[15:8];
                    state  <= ST_W1;
                end else begin
                    case (state)
                        ST_W1: begin
                            seq_q <= din[11:0];
                            state <= ST_W2;
                        end
                        ST_W2:   state <= ST_W0;
                        default: state <= ST_W0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_dllp_ack_nak_rx.sv
// Self-checking bench for dllp_ack_nak_rx: directed cases plus random frames against a frame-level model.
module tb_dllp_ack_nak_rx;

    localparam logic [7:0] T_ACK = 8'h00;
    localparam logic [7:0] T_NAK = 8'h10;
    localparam logic [7:0] T_UFC = 8'h80;

    logic        clk;
    logic        reset_n;
    logic [15:0] din;
    logic        din_valid;
    logic        sop;
    logic        busy_n;
    logic [1:0]  ack_nack;
    logic [11:0] seq;
    logic        crc_err;
    logic [7:0]  drop_cnt;
    dllp_pkg::dllp_state_e fsm_state;

    int n_checks;
    int n_errors;

    // Reference model: words of the frame being collected, and the undelivered result ({code, seq}).
    logic [15:0] m_frame[$];
    logic [13:0] exp_q[$];
    logic [11:0] m_last_seq;
    logic        m_crc_err;
    logic [7:0]  m_drop;

    dllp_ack_nak_rx dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (din),
        .din_valid (din_valid),
        .sop       (sop),
        .busy_n    (busy_n),
        .ack_nack  (ack_nack),
        .seq       (seq),
        .crc_err   (crc_err),
        .drop_cnt  (drop_cnt),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [31:0] msg);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ msg[i]) c = (c << 1) ^ 16'h100B;
            else                c = c << 1;
        end
        return c;
    endfunction

    function automatic logic pick_busy(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // ---------------- model ----------------
    task automatic model_reset();
        m_frame.delete();
        exp_q.delete();
        m_last_seq = 12'h000;
        m_crc_err  = 1'b0;
        m_drop     = 8'h00;
    endtask

    task automatic check_outputs(input logic b);
        logic give;
        give = (exp_q.size() > 0) && b;
        check_val("ack_nack", {30'd0, ack_nack}, give ? {30'd0, exp_q[0][13:12]} : 32'd0);
        check_val("seq", {20'd0, seq}, give ? {20'd0, exp_q[0][11:0]} : {20'd0, m_last_seq});
        check_val("crc_err", {31'd0, crc_err}, {31'd0, m_crc_err});
        check_val("drop_cnt", {24'd0, drop_cnt}, {24'd0, m_drop});
    endtask

    task automatic model_step(input logic v, input logic s, input logic [15:0] d, input logic b);
        logic        err;
        logic        ok;
        logic [15:0] w0, w1, w2;
        logic [13:0] r;
        err = 1'b0;
        if (exp_q.size() > 0 && b) begin
            r = exp_q.pop_front();
            m_last_seq = r[11:0];
        end
        if (v) begin
            if (s) begin
                if (m_frame.size() > 0) err = 1'b1;
                m_frame.delete();
                m_frame.push_back(d);
            end else if (m_frame.size() > 0) begin
                m_frame.push_back(d);
                if (m_frame.size() == 3) begin
                    w0 = m_frame[0];
                    w1 = m_frame[1];
                    w2 = m_frame[2];
                    ok = 1'b1;
`ifdef DLLP_CRC_CHECK_EN
                    ok = (w2 == ~ref_crc({w0, w1}));
`endif
                    if (!ok) begin
                        err = 1'b1;
                    end else if (w0[15:8] == T_ACK || w0[15:8] == T_NAK) begin
                        r = {(w0[15:8] == T_ACK) ? 2'b01 : 2'b10, w1[11:0]};
                        if (exp_q.size() > 0) begin
                            void'(exp_q.pop_front());
                            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                        end
                        exp_q.push_back(r);
                    end
                    m_frame.delete();
                end
            end
        end
        m_crc_err = err;
    endtask

    // ---------------- drivers ----------------
    task automatic cycle(input logic v, input logic s, input logic [15:0] d, input logic b);
        @(negedge clk);
        din_valid = v;
        sop       = s;
        din       = d;
        busy_n    = b;
        #1;
        check_outputs(b);
        @(posedge clk);
        model_step(v, s, d, b);
    endtask

    task automatic idle(input int n, input int mode);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'($urandom), pick_busy(mode));
    endtask

    task automatic send_frame(input logic [7:0] t, input logic [11:0] sq, input logic [15:0] flip,
                              input int nwords, input int mode, input logic gaps);
        logic [15:0] w [3];
        w[0] = {t, 8'h00};
        w[1] = {4'h0, sq};
        w[2] = ~ref_crc({w[0], w[1]}) ^ flip;
        for (int i = 0; i < nwords; i++) begin
            cycle(1'b1, (i == 0), w[i], pick_busy(mode));
            if (gaps && $urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 16'($urandom), pick_busy(mode));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        din_valid = 1'b0;
        sop       = 1'b0;
        busy_n    = 1'b1;
        model_reset();
        #1;
        check_outputs(1'b1);
        check_val("rst_state", {30'd0, fsm_state}, {30'd0, dllp_pkg::ST_W0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        din       = 16'h0000;
        din_valid = 1'b0;
        sop       = 1'b0;
        busy_n    = 1'b1;
        model_reset();
        apply_reset();

        send_frame(T_ACK, 12'h005, 16'h0000, 3, 1, 1'b0);
        idle(3, 1);
        send_frame(T_NAK, 12'hFFF, 16'h0000, 3, 1, 1'b0);
        idle(2, 1);
        send_frame(T_UFC, 12'h123, 16'h0000, 3, 1, 1'b0);
        idle(2, 1);
        send_frame(T_ACK, 12'h010, 16'h0001, 3, 1, 1'b0);
        idle(3, 1);

        send_frame(T_ACK, 12'h001, 16'h0000, 3, 0, 1'b0);
        send_frame(T_NAK, 12'h002, 16'h0000, 3, 0, 1'b0);
        idle(2, 0);
        check_val("drop_after_overwrite", {24'd0, drop_cnt}, 32'd1);
        idle(3, 1);

        cycle(1'b1, 1'b1, {T_ACK, 8'h00}, 1'b1);
        send_frame(T_ACK, 12'h020, 16'h0000, 3, 1, 1'b0);
        idle(3, 1);

        send_frame(T_NAK, 12'h003, 16'h0000, 3, 0, 1'b0);
        cycle(1'b1, 1'b1, {T_ACK, 8'h00}, 1'b0);
        cycle(1'b1, 1'b0, {4'h0, 12'h030}, 1'b0);
        apply_reset();
        idle(2, 1);
        send_frame(T_ACK, 12'h040, 16'h0000, 3, 1, 1'b0);
        idle(3, 1);

        for (int f = 0; f < 300; f++) begin
            logic [7:0]  t;
            logic [15:0] flip;
            int          nw;
            case ($urandom_range(0, 3))
                0: t = T_ACK;
                1: t = T_NAK;
                2: t = T_UFC;
                default: t = 8'($urandom);
            endcase
            flip = ($urandom_range(0, 4) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
            nw   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 3;
            send_frame(t, 12'($urandom), flip, nw, 2, 1'b1);
            if ($urandom_range(0, 5) == 0) cycle(1'b1, 1'b0, 16'($urandom), pick_busy(2));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 2);
        end
        idle(3, 1);

        for (int f = 0; f < 258; f++) begin
            send_frame(($urandom_range(0, 1) == 0) ? T_ACK : T_NAK, 12'($urandom), 16'h0000, 3, 0, 1'b0);
        end
        idle(1, 0);
        check_val("drop_sat", {24'd0, drop_cnt}, 32'hFF);
        idle(3, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
